// File: rtl/ascii_frame_tx_pkg.sv
// ============================================================================
// Module : ascii_frame_tx_pkg
// Brief  : Shared ASCII text constants and frame-emitter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ascii_frame_tx_pkg;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DIGIT = 2'd1;
    localparam state_t ST_CR    = 2'd2;
    localparam state_t ST_LF    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ascii_frame_tx.sv
// ============================================================================
// Module : ascii_frame_tx
// Brief  : Snapshots a row of ASCII counter digits and streams them MSB-first
//          over valid/ready, with optional leading-zero blanking and CR LF.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ascii_frame_tx
    import ascii_frame_tx_pkg::*;
#(
    parameter int         DIGITS        = 4,
    parameter bit         EMIT_CRLF     = 1'b1,
    parameter bit         BLANK_LEADING = 1'b0,
    parameter logic [7:0] ZERO_CHAR     = CHAR_ZERO
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8*DIGITS-1:0] digits_in,
    input  logic                trigger,
    output logic                busy,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic                frame_done,
    output logic                dropped
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              r_state;
    logic [8*DIGITS-1:0] r_snap;
    logic [IW-1:0]       r_idx;
    logic                r_blank_run;

    logic [7:0]          w_first_byte;
    logic                w_first_blank;
    logic [IW-1:0]       w_next_idx;
    logic [7:0]          w_next_byte;
    logic                w_next_blank;

    // The first byte comes straight from digits_in so it can be presented
    // in the cycle after the trigger, in parallel with the snapshot load.
    assign w_first_byte  = digits_in[8*(DIGITS-1) +: 8];
    assign w_first_blank = BLANK_LEADING && (DIGITS > 1) && (w_first_byte == ZERO_CHAR);

    // r_blank_run remembers that every more-significant digit was blanked.
    assign w_next_idx   = r_idx - 1'b1;
    assign w_next_byte  = r_snap[{w_next_idx, 3'b000} +: 8];
    assign w_next_blank = BLANK_LEADING && r_blank_run && (w_next_idx != '0)
                          && (w_next_byte == ZERO_CHAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_snap      <= '0;
            r_idx       <= '0;
            r_blank_run <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            dropped     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            dropped    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (trigger) begin
                        r_snap      <= digits_in;
                        r_idx       <= IW'(DIGITS - 1);
                        r_blank_run <= w_first_blank;
                        tx_data     <= w_first_blank ? CHAR_SPACE : w_first_byte;
                        tx_valid    <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= ST_DIGIT;
                    end
                end

                ST_DIGIT: begin
                    if (tx_ready) begin
                        if (r_idx == '0) begin
                            if (EMIT_CRLF) begin
                                tx_data <= CHAR_CR;
                                r_state <= ST_CR;
                            end else begin
                                tx_valid   <= 1'b0;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                                r_state    <= ST_IDLE;
                            end
                        end else begin
                            r_idx       <= w_next_idx;
                            r_blank_run <= w_next_blank;
                            tx_data     <= w_next_blank ? CHAR_SPACE : w_next_byte;
                        end
                    end
                end

                ST_CR: begin
                    if (tx_ready) begin
                        tx_data <= CHAR_LF;
                        r_state <= ST_LF;
                    end
                end

                default: begin
                    if (tx_ready) begin
                        tx_valid   <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
            endcase

            if ((r_state != ST_IDLE) && trigger) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/ascii_frame_tx.md
Name: ascii_frame_tx

Overview:
- Downstream consumer of a cascade of ASCII decimal digit counters.
- Snapshots the concatenated counter digits on a trigger pulse and emits them as a byte stream, most-significant digit first, over a valid/ready handshake.
- Optionally appends CR LF to each frame; feeds the UART transmitter / text sink.
- Decouples the free-running counters from a slow or back-pressuring byte sink.

Parameters:
- DIGITS, 4, number of 8-bit ASCII digits in digits_in (>=1).
- EMIT_CRLF, 1, 1 = append 8'h0D, 8'h0A after the last digit; 0 = digits only.
- BLANK_LEADING, 0, 1 = replace leading ZERO_CHAR digits with 8'h20; the least-significant digit is never blanked.
- ZERO_CHAR, 8'h30, code of digit zero as produced by the counters.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- digits_in  in  8*DIGITS  concatenated ASCII digits; byte 0 [7:0] is least significant.
- trigger  in  1  one-cycle request to snapshot and send a frame.
- busy  out  1  high while a frame is held or being sent.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.
- dropped  out  1  one-cycle pulse when a trigger is ignored because busy.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE; busy, tx_valid, frame_done and dropped are 0.
  - tx_data is 8'h00; snapshot and index registers are 0.
- States: IDLE, DIGIT, CR, LF.
- IDLE:
  - On trigger, register the full digits_in into the snapshot, set index = DIGITS-1, and go to DIGIT.
  - The first byte appears with tx_valid=1 on the next cycle (latency 1).
- DIGIT:
  - tx_data = snapshot byte[index], after blanking.
  - On accept: if index==0, go to CR when EMIT_CRLF=1, else finish; otherwise decrement index.
- CR:
  - tx_data = 8'h0D; on accept go to LF.
- LF:
  - tx_data = 8'h0A; on accept finish.
- Finish:
  - Go to IDLE.
  - frame_done=1 for exactly the cycle following the final accept.
  - busy=0 in that same cycle.
- Handshake:
  - tx_data and tx_valid are registered outputs.
  - While tx_valid=1 and tx_ready=0, tx_data holds stable.
  - tx_valid stays high until accepted and is never withdrawn.
  - Back-to-back accepts give one byte per cycle.
  - tx_ready while tx_valid=0 has no effect.
- busy:
  - busy = (state != IDLE), registered.
- Trigger while busy:
  - Ignored; the snapshot is unchanged; dropped=1 the following cycle.
- Trigger in the frame_done cycle:
  - Accepted, because state is IDLE; the new frame starts with no gap.
- Blanking (BLANK_LEADING=1):
  - Tracked MSB-first; a digit is blanked while all more-significant digits were ZERO_CHAR and the current digit equals ZERO_CHAR.
  - Index 0 is always sent as-is.
  - Non-digit codes pass unchanged and end blanking.
- Data rules:
  - Digits are never modified except by blanking; there is no arithmetic on the digits.
  - The snapshot is taken in a single cycle, so carries rippling in the counters afterwards do not affect the frame.
- Reset mid-frame:
  - The frame is aborted immediately; no frame_done is produced; the block restarts in IDLE.
- Index counter width:
  - $clog2(DIGITS), minimum 1 bit.

Decomposition:
- Shared package (text constants reused by other text emitters):
  - ASCII constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_SPACE=8'h20, CHAR_ZERO=8'h30.
  - State typedef IDLE/DIGIT/CR/LF.
- No sub-module: the single FSM plus snapshot register is the natural unit.

Test Plan:
- Default params, digits_in=32'h31_32_33_34, tx_ready=1, trigger pulse at cycle 0:
  - Bytes 31,32,33,34,0D,0A are accepted on cycles 1-6.
  - frame_done pulses at cycle 7; busy is high on cycles 1-6.
- Back-pressure: same frame with tx_ready toggling 1,0,0,1,...:
  - tx_data holds each byte while stalled; byte order is unchanged; no byte is duplicated or lost.
- BLANK_LEADING=1, digits 30_30_37_30:
  - Output is 20,20,37,30,0D,0A.
  - With digits 30_30_30_30, output is 20,20,20,30,0D,0A.
- Trigger at cycle 3 of an active frame with digits_in changed to 39_39_39_39:
  - dropped pulses at cycle 4; the frame still carries the old digits.
  - A trigger in the frame_done cycle starts a new frame with 39s on the next cycle.
- EMIT_CRLF=0, DIGITS=1, digits 35:
  - Single byte 35 is sent; frame_done follows acceptance by 1 cycle.
- rst_n asserted low asynchronously mid-frame (between clock edges, after byte 2):
  - tx_valid, busy and frame_done drop to 0 immediately.
  - After release, the next trigger sends a complete frame from the MSB.
